// File: rtl/nibble_pack_ctrl.sv
// Nibble-to-byte sequencing controller: pack, sign/zero extend, replicate.
// Orphaned upper nibbles are flushed as partial bytes after an idle timeout.
module nibble_pack_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_mode,
    input  logic       i_nib_valid,
    input  logic [3:0] i_nib_data,
    output logic       o_nib_ready,
    output logic       o_byte_valid,
    output logic [7:0] o_byte_data,
    input  logic       i_byte_ready,
    output logic       o_byte_partial,
    output logic       o_busy,
    output logic [7:0] o_flush_cnt
);

    typedef enum logic {
        S_IDLE,
        S_HALF
    } state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

    state_t     state;
    state_t     state_nx;
    logic [3:0] held;
    logic [3:0] held_nx;
    logic [7:0] cnt;
    logic [7:0] cnt_nx;
    logic [7:0] data_nx;
    logic       partial_nx;
    logic       load;
    logic       flush;
    logic       nib_acc;
    logic       byte_acc;
    logic       tmo_hit;

    assign o_nib_ready = !o_byte_valid | i_byte_ready;
    assign nib_acc     = i_nib_valid & o_nib_ready;
    assign byte_acc    = o_byte_valid & i_byte_ready;
    assign tmo_hit     = (TMO != 8'd0) && (cnt == TMO);
    assign o_busy      = (state == S_HALF) | o_byte_valid;

    always_comb begin
        state_nx   = state;
        held_nx    = held;
        cnt_nx     = cnt;
        data_nx    = o_byte_data;
        partial_nx = o_byte_partial;
        load       = 1'b0;
        flush      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (nib_acc) begin
                    partial_nx = 1'b0;
                    unique case (i_mode)
                        2'b00: begin
                            held_nx  = i_nib_data;
                            cnt_nx   = 8'd0;
                            state_nx = S_HALF;
                        end
                        2'b01: begin
                            load    = 1'b1;
                            data_nx = {{4{i_nib_data[3]}}, i_nib_data};
                        end
                        2'b10: begin
                            load    = 1'b1;
                            data_nx = {4'h0, i_nib_data};
                        end
                        2'b11: begin
                            load    = 1'b1;
                            data_nx = {8{i_nib_data[0]}};
                        end
                    endcase
                end
            end
            S_HALF: begin
                if (nib_acc) begin
                    load       = 1'b1;
                    data_nx    = {held, i_nib_data};
                    partial_nx = 1'b0;
                    cnt_nx     = 8'd0;
                    state_nx   = S_IDLE;
                end else if (tmo_hit && o_nib_ready) begin
                    load       = 1'b1;
                    flush      = 1'b1;
                    data_nx    = {held, 4'h0};
                    partial_nx = 1'b1;
                    cnt_nx     = 8'd0;
                    state_nx   = S_IDLE;
                end else if (cnt != TMO) begin
                    cnt_nx = cnt + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= S_IDLE;
            held           <= 4'h0;
            cnt            <= 8'd0;
            o_byte_valid   <= 1'b0;
            o_byte_data    <= 8'h00;
            o_byte_partial <= 1'b0;
            o_flush_cnt    <= 8'd0;
        end else begin
            state <= state_nx;
            held  <= held_nx;
            cnt   <= cnt_nx;
            // A new load takes priority over the transfer-driven clear.
            if (load) begin
                o_byte_valid   <= 1'b1;
                o_byte_data    <= data_nx;
                o_byte_partial <= partial_nx;
            end else if (byte_acc) begin
                o_byte_valid <= 1'b0;
            end
            if (flush && (o_flush_cnt != 8'hFF)) begin
                o_flush_cnt <= o_flush_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_nibble_pack_ctrl.sv
// Randomized scoreboard bench for nibble_pack_ctrl.
// A transaction-level model predicts every byte, its timing and flags.
module tb_nibble_pack_ctrl;

    localparam int T = 15;

    logic       clk = 1'b0;
    logic       i_rst_n;
    logic [1:0] i_mode;
    logic       i_nib_valid;
    logic [3:0] i_nib_data;
    logic       o_nib_ready;
    logic       o_byte_valid;
    logic [7:0] o_byte_data;
    logic       i_byte_ready;
    logic       o_byte_partial;
    logic       o_busy;
    logic [7:0] o_flush_cnt;

    nibble_pack_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .i_clk         (clk),
        .i_rst_n       (i_rst_n),
        .i_mode        (i_mode),
        .i_nib_valid   (i_nib_valid),
        .i_nib_data    (i_nib_data),
        .o_nib_ready   (o_nib_ready),
        .o_byte_valid  (o_byte_valid),
        .o_byte_data   (o_byte_data),
        .i_byte_ready  (i_byte_ready),
        .o_byte_partial(o_byte_partial),
        .o_busy        (o_busy),
        .o_flush_cnt   (o_flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       p;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    bit       m_half;
    bit       m_valid;
    int       m_idle;
    int       m_flush;
    logic [3:0] m_held;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [7:0] ext_byte(logic [1:0] m, logic [3:0] n);
        int s;
        if (m == 2'b01) begin
            s = n[3] ? int'(n) - 16 : int'(n);
            return s[7:0];
        end
        if (m == 2'b10) return 8'(n);
        return n[0] ? 8'hFF : 8'h00;
    endfunction

    // Reference model, evaluated once per cycle with the inputs of the next edge.
    initial begin
        m_half = 0; m_valid = 0; m_idle = 0; m_flush = 0; m_held = 0;
        forever begin
            bit rdy, acc, bacc, pushed;
            exp_t e;
            @(negedge clk);
            if (!i_rst_n) begin
                m_half = 0; m_valid = 0; m_idle = 0; m_flush = 0;
                q.delete();
            end else begin
                chk("byte_valid", 32'(o_byte_valid), 32'(m_valid));
                chk("busy", 32'(o_busy), 32'(m_half | m_valid));
                chk("flush_cnt", 32'(o_flush_cnt), 32'(m_flush));
                rdy = !m_valid || i_byte_ready;
                chk("nib_ready", 32'(o_nib_ready), 32'(rdy));
                acc = i_nib_valid && rdy;
                bacc = m_valid && i_byte_ready;
                pushed = 0;
                if (m_half) begin
                    if (acc) begin
                        e.d = 8'(m_held * 16 + i_nib_data); e.p = 0;
                        q.push_back(e); pushed = 1; m_half = 0;
                    end else if (T != 0 && m_idle >= T && rdy) begin
                        e.d = 8'(m_held * 16); e.p = 1;
                        q.push_back(e); pushed = 1; m_half = 0;
                        if (m_flush < 255) m_flush++;
                    end else begin
                        m_idle++;
                    end
                end else if (acc) begin
                    if (i_mode == 2'b00) begin
                        m_half = 1; m_held = i_nib_data; m_idle = 0;
                    end else begin
                        e.d = ext_byte(i_mode, i_nib_data); e.p = 0;
                        q.push_back(e); pushed = 1;
                    end
                end
                m_valid = pushed ? 1'b1 : (bacc ? 1'b0 : m_valid);
            end
        end
    end

    // Output monitor: every transferred byte is matched against the queue.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (i_rst_n && o_byte_valid && i_byte_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_byte", 32'(o_byte_data), 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("byte_data", 32'(o_byte_data), 32'(e.d));
                    chk("byte_partial", 32'(o_byte_partial), 32'(e.p));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    task automatic cyc(input bit v, input logic [1:0] m,
                       input logic [3:0] n, input bit r);
        i_nib_valid  = v;
        i_mode       = m;
        i_nib_data   = n;
        i_byte_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(0, 2'b00, 4'h0, 1);
    endtask

    task automatic async_reset();
        i_rst_n = 1'b0;
        #2;
        chk("rst_valid", 32'(o_byte_valid), 0);
        chk("rst_data", 32'(o_byte_data), 0);
        chk("rst_partial", 32'(o_byte_partial), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_flush", 32'(o_flush_cnt), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    initial begin
        int dens;
        i_rst_n = 1'b0;
        i_nib_valid = 0; i_mode = 0; i_nib_data = 0; i_byte_ready = 1;
        #1;
        chk("init_valid", 32'(o_byte_valid), 0);
        chk("init_busy", 32'(o_busy), 0);
        repeat (3) @(posedge clk);
        #1;
        i_rst_n = 1'b1;

        cyc(1, 2'b00, 4'hA, 1);
        cyc(1, 2'b00, 4'h5, 1);
        idle(2);

        cyc(1, 2'b01, 4'h9, 1);
        cyc(1, 2'b10, 4'h9, 1);
        cyc(1, 2'b11, 4'h3, 1);
        idle(2);

        cyc(1, 2'b00, 4'hC, 1);
        idle(20);
        chk("flush_after_timeout", 32'(o_flush_cnt), 1);

        cyc(1, 2'b10, 4'h4, 0);
        repeat (3) cyc(1, 2'b01, 4'h8, 0);
        chk("held_data", 32'(o_byte_data), 32'h04);
        cyc(1, 2'b01, 4'h8, 1);
        idle(2);

        cyc(1, 2'b00, 4'h7, 1);
        idle(T);
        cyc(1, 2'b00, 4'h2, 1);
        idle(3);
        chk("flush_unchanged", 32'(o_flush_cnt), 1);

        cyc(1, 2'b00, 4'hB, 1);
        cyc(0, 2'b00, 4'h0, 1);
        async_reset();
        cyc(1, 2'b11, 4'h1, 0);
        cyc(0, 2'b00, 4'h0, 0);
        async_reset();
        cyc(1, 2'b00, 4'h1, 1);
        cyc(1, 2'b00, 4'h2, 1);
        idle(3);

        dens = 90;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0: dens = 90;
                    1: dens = 50;
                    default: dens = 4;
                endcase
            end
            cyc($urandom_range(0, 99) < dens, 2'($urandom_range(0, 3)),
                4'($urandom_range(0, 15)), $urandom_range(0, 99) < 75);
        end
        idle(40);

        for (int i = 0; i < 260; i++) begin
            cyc(1, 2'b00, 4'(i), 1);
            idle(T + 2);
        end
        chk("flush_saturated", 32'(o_flush_cnt), 255);
        idle(5);
        chk("queue_drained", 32'(q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nibble_pack_ctrl.md
Name: nibble_pack_ctrl

Overview:
- Sequencing controller for the nibble/byte vector datapath (concatenate, sign-extend, zero-extend, replicate).
- Accepts a stream of 4-bit nibbles over a valid/ready handshake and emits 8-bit bytes over a valid/ready handshake.
- Pairs nibbles into bytes in PACK mode, with a timeout flush of an orphaned nibble.
- Sits between a nibble-wide source (keypad/UART nibble decoder) and byte-wide consumers.

Parameters:
- TIMEOUT_CYCLES, 15: idle cycles in S_HALF before the held nibble is flushed. 0 disables the timeout. Legal range 0..255.

Ports:
- i_clk  input  1  system clock, rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_mode  input  2  00 PACK, 01 SEXT, 10 ZEXT, 11 REPL
- i_nib_valid  input  1  input nibble valid
- i_nib_data  input  4  input nibble
- o_nib_ready  output  1  controller can accept a nibble this cycle
- o_byte_valid  output  1  output byte valid
- o_byte_data  output  8  output byte
- i_byte_ready  input  1  consumer accepts the byte this cycle
- o_byte_partial  output  1  current output byte is a timeout flush; qualified by o_byte_valid
- o_busy  output  1  nibble held (S_HALF) or output valid pending
- o_flush_cnt  output  8  count of timeout flushes; saturates at 255

Behaviour:
- Reset (async assert, sync deassert handled upstream) clears all outputs and registers: o_byte_valid=0, o_byte_data=0, o_byte_partial=0, o_busy=0, o_flush_cnt=0, state=S_IDLE, timeout counter=0.
- Reset mid-operation discards the held nibble and any pending byte.
- Nibble accept: nib_acc = i_nib_valid & o_nib_ready.
  - o_nib_ready = !o_byte_valid | i_byte_ready (combinational).
- Byte transfer: byte_acc = o_byte_valid & i_byte_ready. It clears o_byte_valid unless a new byte loads in the same cycle; load wins.
- Output register holds stable while o_byte_valid=1 and i_byte_ready=0.
- State S_IDLE:
  - i_mode is sampled only on nib_acc in S_IDLE.
  - PACK: store nibble as upper half, go to S_HALF.
  - SEXT: load {{4{n[3]}},n}.
  - ZEXT: load {4'h0,n}.
  - REPL: load {8{n[0]}}.
  - Non-PACK loads assert o_byte_valid on the next cycle, i.e. 1-cycle latency, and stay in S_IDLE.
- State S_HALF:
  - i_mode is ignored; mode is locked to PACK.
  - On nib_acc: load {held,n}, o_byte_partial=0, go to S_IDLE, clear the timeout counter.
  - The byte is valid the cycle after the second nibble is accepted.
- Timeout:
  - In S_HALF the counter increments each cycle without nib_acc; it saturates at TIMEOUT_CYCLES.
  - When counter == TIMEOUT_CYCLES, TIMEOUT_CYCLES != 0, no nib_acc and output space is available (!o_byte_valid | i_byte_ready):
    - load {held,4'h0}
    - o_byte_partial=1
    - o_flush_cnt += 1 (saturating)
    - go to S_IDLE, clear the counter
  - If output space is not available, the flush waits with the counter held at saturation.
  - Simultaneous nib_acc and timeout: nib_acc wins and the pair completes normally; no flush.
- o_busy = (state==S_HALF) | o_byte_valid.
- Throughput: one byte per cycle in non-PACK modes and one byte per two nibbles in PACK, with continuous i_byte_ready=1.

Test Plan:
- Reset then PACK nibbles 0xA,0x5 back-to-back, i_byte_ready=1 -> o_byte_data=0xA5, valid one cycle after 2nd accept, o_byte_partial=0.
- SEXT nibble 0x9, then ZEXT 0x9, then REPL 0x3, consecutive cycles -> bytes 0xF9, 0x09, 0xFF on three consecutive cycles.
- PACK nibble 0xC, no further input, TIMEOUT_CYCLES=15 -> byte 0xC0 with o_byte_partial=1 after 15 idle cycles, o_flush_cnt=1.
- Hold i_byte_ready=0 with a byte pending, present a nibble -> o_nib_ready=0 and o_byte_data stable; release ready -> nibble accepted in the same cycle, no byte lost or duplicated.
- Second nibble arrives on the exact timeout cycle (0x7 then 0x2) -> 0x72, o_byte_partial=0, o_flush_cnt unchanged.
- Assert i_rst_n=0 in S_HALF with a byte pending -> all outputs 0 immediately (asynchronous); after release, PACK 0x1,0x2 -> 0x12.
